// File: rtl/pixel_frame_streamer_if.sv
// pixel_frame_streamer_if: colour/valid/latch handshake towards pixel_driver.
interface pixel_frame_streamer_if;
  logic [23:0] px_color;
  logic        px_valid;
  logic        px_reset;
  logic        px_ready;
  modport master (output px_color, px_valid, px_reset, input px_ready);
  modport slave  (input px_color, px_valid, px_reset, output px_ready);
endinterface

// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer: double-buffered frame source, one frame per timer period, streamed to pixel_driver.
module pixel_frame_streamer #(
  parameter int NUM_PIXELS = 150,
  parameter int CLK_HZ     = 16_000_000,
  parameter int FRAME_HZ   = 60,
  parameter int ADDR_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [23:0]            wr_data_i,
  input  logic                   swap_req_i,
  pixel_frame_streamer_if.master px,
  output logic                   busy_o,
  output logic                   swap_pending_o,
  output logic                   frame_done_o,
  output logic                   overrun_o
);
  localparam int PERIOD = CLK_HZ / FRAME_HZ;
  localparam int TW     = PERIOD > 1 ? $clog2(PERIOD) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, SHOW, LATCH} state_t;
  state_t            state_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] idx_q;
  logic              front_q, tick_pending_q, tick_pending_d, swap_pending_q, swap_pending_d;
  logic [23:0]       color_q;
  logic              valid_q, reset_q, frame_done_q, overrun_q;
  logic              tick, start, last;
  // bank select is the MSB of the address: {bank, pixel}
  logic [23:0]       mem [2**(ADDR_W+1)];
  assign tick  = timer_q == TW'(PERIOD - 1);
  assign start = state_q == IDLE && tick_pending_q;
  assign last  = idx_q == ADDR_W'(NUM_PIXELS - 1);
  always_comb begin
    timer_d        = tick ? '0 : timer_q + 1'b1;
    tick_pending_d = (tick_pending_q & ~start) | tick;
    swap_pending_d = (swap_pending_q & ~start) | swap_req_i;
  end
  always_ff @(posedge clk) begin
    if (wr_en_i && {1'b0, wr_addr_i} < (ADDR_W+1)'(NUM_PIXELS))
      mem[{~front_q, wr_addr_i}] <= wr_data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      idx_q          <= '0;
      front_q        <= 1'b0;
      tick_pending_q <= 1'b0;
      swap_pending_q <= 1'b0;
      color_q        <= '0;
      valid_q        <= 1'b0;
      reset_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      tick_pending_q <= tick_pending_d;
      swap_pending_q <= swap_pending_d;
      overrun_q      <= tick & tick_pending_q & ~start;
      frame_done_q   <= 1'b0;
      if (start && swap_pending_q) front_q <= ~front_q;
      case (state_q)
        IDLE: if (tick_pending_q) begin
          idx_q   <= '0;
          state_q <= FETCH;
        end
        FETCH: begin
          color_q <= mem[{front_q, idx_q}];
          valid_q <= 1'b1;
          state_q <= SHOW;
        end
        // the latch request follows the last pixel without a bubble
        SHOW: if (px.px_ready) begin
          color_q <= last ? '0 : color_q;
          valid_q <= last;
          reset_q <= last;
          idx_q   <= last ? idx_q : idx_q + 1'b1;
          state_q <= last ? LATCH : FETCH;
        end
        LATCH: if (px.px_ready) begin
          valid_q      <= 1'b0;
          reset_q      <= 1'b0;
          frame_done_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign px.px_color    = color_q;
  assign px.px_valid    = valid_q;
  assign px.px_reset    = reset_q;
  assign busy_o         = state_q != IDLE;
  assign swap_pending_o = swap_pending_q;
  assign frame_done_o   = frame_done_q;
  assign overrun_o      = overrun_q;
endmodule

// File: tb/tb_pixel_frame_streamer.sv
// tb_pixel_frame_streamer: random-stimulus bench against a bank/frame level reference model.
module tb_pixel_frame_streamer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, swap_req;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy, swap_pending, frame_done, overrun;
  int          checks = 0, errors = 0;
  logic [23:0] bank [2][4];
  bit          front, swp, done_exp;
  int          pix_cnt, frames, ov_cnt;
  pixel_frame_streamer_if px ();
  pixel_frame_streamer #(.NUM_PIXELS(4), .CLK_HZ(1000), .FRAME_HZ(10), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .swap_req_i(swap_req), .px(px), .busy_o(busy), .swap_pending_o(swap_pending),
    .frame_done_o(frame_done), .overrun_o(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    if (a < 8'd4) bank[~front][a[1:0]] = d;
    step;
    wr_en = 1'b0;
  endtask
  task automatic swap;
    swap_req = 1'b1; swp = 1'b1;
    step;
    swap_req = 1'b0;
  endtask
  task automatic wait_frames(input int n);
    int k = 0;
    while (frames < n && k < 400) begin step; k++; end
    chk("frame_wait", frames >= n, 1);
  endtask
  task automatic wait_pix(input int n);
    int k = 0;
    while (pix_cnt != n && k < 400) begin step; k++; end
    chk("pixel_wait", pix_cnt, n);
  endtask
  task automatic wait_idle;
    int k = 0;
    while ((busy || pix_cnt != 0) && k < 400) begin step; k++; end
    chk("idle_wait", busy, 0);
  endtask
  // Observes every accepted transfer; front bank is resolved when a frame's first pixel is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      pix_cnt  = 0;
      done_exp = 1'b0;
    end else begin
      chk("frame_done", frame_done, done_exp);
      done_exp = 1'b0;
      if (overrun) ov_cnt++;
      if (px.px_valid && px.px_ready) begin
        if (px.px_reset) begin
          chk("latch_color", px.px_color, 0);
          chk("pix_per_frame", pix_cnt, 4);
          pix_cnt  = 0;
          done_exp = 1'b1;
          frames++;
        end else begin
          if (pix_cnt == 0 && swp) begin front = ~front; swp = 1'b0; end
          chk("pixel", px.px_color, bank[front][pix_cnt % 4]);
          pix_cnt++;
        end
      end
    end
  end
  initial begin
    int v, f;
    rst_n = 1'b0; wr_en = 1'b0; swap_req = 1'b0; wr_addr = '0; wr_data = '0;
    px.px_ready = 1'b0;
    front = 1'b0; swp = 1'b0; frames = 0; ov_cnt = 0;
    repeat (3) step;
    chk("rst_color", px.px_color, 0);
    chk("rst_valid", px.px_valid, 0);
    chk("rst_reset", px.px_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    wr(0, 24'h110000); wr(1, 24'h002200); wr(2, 24'h000033); wr(3, 24'hFFFFFF);
    swap;
    chk("swap_pending_set", swap_pending, 1);
    px.px_ready = 1'b1;
    wait_frames(1);
    chk("front_after_first", front, 1);
    // backpressure on pixel 2 of the second frame
    wait_pix(2);
    px.px_ready = 1'b0;
    step;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("hold_valid", px.px_valid, 1);
      chk("hold_color", px.px_color, 24'h000033);
    end
    px.px_ready = 1'b1;
    wait_frames(2);
    // new content and swap requested in the middle of frame 3
    wait_pix(1);
    px.px_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'(i), 24'($urandom));
    wr(8'd4, 24'($urandom));
    swap;
    chk("swap_pending_mid", swap_pending, 1);
    chk("busy_mid", busy, 1);
    px.px_ready = 1'b1;
    wait_frames(3);
    wait_pix(1);
    chk("swap_pending_applied", swap_pending, 0);
    wait_frames(4);
    // random backpressure, writes and swaps
    for (int c = 0; c < 700; c++) begin
      px.px_ready = $urandom_range(0, 3) != 0;
      if (pix_cnt != 0 && $urandom_range(0, 3) == 0) begin
        wr_en = 1'b1; wr_addr = 8'($urandom_range(0, 6)); wr_data = 24'($urandom);
        if (wr_addr < 8'd4) bank[~front][wr_addr[1:0]] = wr_data;
      end else wr_en = 1'b0;
      if (pix_cnt != 0 && $urandom_range(0, 39) == 0) begin swap_req = 1'b1; swp = 1'b1; end
      else swap_req = 1'b0;
      step;
    end
    wr_en = 1'b0; swap_req = 1'b0; px.px_ready = 1'b1;
    chk("random_frames", frames > 8, 1);
    chk("no_overrun", ov_cnt, 0);
    wait_idle;
    // overrun: stall a fresh frame across two further ticks
    px.px_ready = 1'b0;
    v = 0;
    while (!busy && v < 200) begin step; v++; end
    chk("stall_start", busy, 1);
    repeat (250) step;
    chk("overrun_count", ov_cnt, 1);
    f = frames;
    px.px_ready = 1'b1;
    wait_frames(f + 1);
    v = 0;
    while (!busy && v < 10) begin step; v++; end
    chk("immediate_start", busy, 1);
    wait_frames(f + 2);
    // asynchronous reset while pixel 1 is being shown
    wait_idle;
    wait_pix(1);
    px.px_ready = 1'b0;
    step; step;
    chk("pre_reset_valid", px.px_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", px.px_valid, 0);
    chk("async_reset", px.px_reset, 0);
    chk("async_busy", busy, 0);
    front = 1'b0; swp = 1'b0;
    step; step;
    rst_n = 1'b1;
    px.px_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'(i), 24'($urandom));
    swap;
    v = 0;
    for (int i = 0; i < 90; i++) begin
      if (px.px_valid) v++;
      step;
    end
    chk("quiet_after_reset", v, 0);
    f = frames;
    wait_frames(f + 1);
    chk("final_overrun", ov_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
